step_coordinator: RTL and testbench

// - Next-generation coordinator between FPGA-side IRAM/DRAM and the slow CNT processor core.
// - Replaces free-running phase clocks with per-instruction sequencing: fetch INST at PC, pre-load DI (load), pulse CLKA, pulse CLKB, commit DO (store).
// - Adds parametrised widths and phase timing, run/single-step modes, HALT detect, I2C-load hold-off and a step watchdog.

---
 rtl/step_coordinator_pkg.sv | 10 +
 rtl/step_coordinator_if.sv | 15 +
 rtl/step_coordinator_phase_timer.sv | 18 +
 rtl/step_coordinator.sv | 129 ++++++++++++
 tb/tb_step_coordinator.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/step_coordinator_pkg.sv
// step_coordinator_pkg: state encoding, default opcodes and helpers shared by the step coordinator.
package step_coordinator_pkg;
    typedef enum logic [3:0] {IDLE, FETCH, LATCH, RD, PHA, GAPA, PHB, GAPB, HOLD, PAUSE, DONE} state_e;
    localparam logic [3:0] OPC_LD_DEF = 4'h1;
    localparam logic [3:0] OPC_ST_DEF = 4'h2;
    localparam logic [3:0] OPC_HALT_DEF = 4'hF;
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/step_coordinator_if.sv
// step_coordinator_if: IRAM/DRAM bus between the coordinator (master) and the FPGA-side memories (slave).
interface step_coordinator_if #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] iram_addr;
    logic [INST_W-1:0] iram_data;
    logic [ADDR_W-1:0] dram_addr;
    logic dram_we;
    logic [DATA_W-1:0] dram_wdata;
    logic [DATA_W-1:0] dram_rdata;
    modport master (output iram_addr, dram_addr, dram_we, dram_wdata, input iram_data, dram_rdata);
    modport slave (input iram_addr, dram_addr, dram_we, dram_wdata, output iram_data, dram_rdata);
endinterface

// File: rtl/step_coordinator_phase_timer.sv
// step_coordinator_phase_timer: loadable down-counter; done while the count sits at zero.
module step_coordinator_phase_timer #(
    parameter int W = 3
) (
    input logic clk,
    input logic rst_n,
    input logic load,
    input logic [W-1:0] load_val,
    output logic done
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_val : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign done = (cnt_q == '0);
endmodule

// File: rtl/step_coordinator.sv
// step_coordinator: sequences one CNT-core instruction at a time (fetch, optional load, CLKA, CLKB, optional store).
module step_coordinator
    import step_coordinator_pkg::*;
#(
    parameter int INST_W = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int OPC_W = 4,
    parameter logic [OPC_W-1:0] OPC_LD = OPC_W'(OPC_LD_DEF),
    parameter logic [OPC_W-1:0] OPC_ST = OPC_W'(OPC_ST_DEF),
    parameter logic [OPC_W-1:0] OPC_HALT = OPC_W'(OPC_HALT_DEF),
    parameter int PHASE_CYC = 4,
    parameter int GAP_CYC = 2,
    parameter int MAX_STEPS = 0
) (
    input logic GCLK,
    input logic RESET,
    input logic EN,
    input logic STEP_MODE,
    input logic IICING,
    output logic ENC,
    output logic CACK,
    output logic TIMEOUT,
    output logic CLKA,
    output logic CLKB,
    input logic [ADDR_W-1:0] PC,
    output logic [INST_W-1:0] INST,
    output logic [DATA_W-1:0] DI,
    input logic [DATA_W-1:0] DO,
    output logic [15:0] step_cnt,
    step_coordinator_if.master mem
);
    localparam int TW = $clog2(max2(PHASE_CYC, GAP_CYC) + 1);
    state_e state_q, state_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [DATA_W-1:0] di_q, di_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0] iaddr_q, iaddr_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic mode_q, mode_d, tout_q, tout_d, we_q, we_d;
    logic clka_q, clka_d, clkb_q, clkb_d, enc_q, enc_d, cack_q, cack_d;
    logic [OPC_W-1:0] lat_opc, inst_opc;
    logic t_done, boundary, wd_hit;
    logic [TW-1:0] t_load;
    always_comb begin
        lat_opc = mem.iram_data[INST_W-1 -: OPC_W];
        inst_opc = inst_q[INST_W-1 -: OPC_W];
        boundary = (state_q == GAPB) && t_done;
        cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        wd_hit = (MAX_STEPS != 0) && (cnt_inc == 16'(MAX_STEPS));
        state_d = state_q;
        case (state_q)
            IDLE: if (EN && !IICING) state_d = FETCH;
            FETCH: state_d = LATCH;
            LATCH: state_d = (lat_opc == OPC_HALT) ? DONE : (lat_opc == OPC_LD) ? RD : PHA;
            RD: state_d = PHA;
            PHA: if (t_done) state_d = GAPA;
            GAPA: if (t_done) state_d = PHB;
            PHB: if (t_done) state_d = GAPB;
            GAPB: if (t_done) state_d = wd_hit ? DONE : IICING ? HOLD : mode_q ? PAUSE : EN ? FETCH : IDLE;
            HOLD: state_d = !EN ? IDLE : !IICING ? FETCH : HOLD;
            PAUSE, DONE: if (!EN) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        mode_d = (state_q == IDLE) ? STEP_MODE : mode_q;
        cnt_d = (state_q == IDLE && state_d == FETCH) ? 16'd0 : boundary ? cnt_inc : cnt_q;
        tout_d = (state_d == IDLE) ? 1'b0 : (boundary && wd_hit) ? 1'b1 : tout_q;
        inst_d = (state_q == LATCH) ? mem.iram_data : inst_q;
        di_d = (state_q == RD) ? mem.dram_rdata : di_q;
        iaddr_d = (state_d == FETCH) ? PC : iaddr_q;
        we_d = (state_q == PHB) && t_done && (inst_opc == OPC_ST);
        wdata_d = we_d ? DO : wdata_q;
        clka_d = (state_d == PHA);
        clkb_d = (state_d == PHB);
        enc_d = state_d inside {FETCH, LATCH, RD, PHA, GAPA, PHB, GAPB};
        cack_d = state_d inside {PAUSE, DONE};
        t_load = (state_d == PHA || state_d == PHB) ? TW'(PHASE_CYC - 1) : TW'(GAP_CYC - 1);
    end
    always_ff @(posedge GCLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            inst_q <= '0;
            di_q <= '0;
            wdata_q <= '0;
            iaddr_q <= '0;
            cnt_q <= '0;
            mode_q <= 1'b0;
            tout_q <= 1'b0;
            we_q <= 1'b0;
            clka_q <= 1'b0;
            clkb_q <= 1'b0;
            enc_q <= 1'b0;
            cack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q <= inst_d;
            di_q <= di_d;
            wdata_q <= wdata_d;
            iaddr_q <= iaddr_d;
            cnt_q <= cnt_d;
            mode_q <= mode_d;
            tout_q <= tout_d;
            we_q <= we_d;
            clka_q <= clka_d;
            clkb_q <= clkb_d;
            enc_q <= enc_d;
            cack_q <= cack_d;
        end
    end
    step_coordinator_phase_timer #(.W(TW)) u_timer (
        .clk(GCLK),
        .rst_n(RESET),
        .load(state_d != state_q),
        .load_val(t_load),
        .done(t_done)
    );
    assign ENC = enc_q;
    assign CACK = cack_q;
    assign TIMEOUT = tout_q;
    assign CLKA = clka_q;
    assign CLKB = clkb_q;
    assign INST = inst_q;
    assign step_cnt = cnt_q;
    // Operand address and load data bypass their registers so a load fits in one RD cycle ahead of CLKA.
    assign DI = (state_q == RD) ? mem.dram_rdata : di_q;
    assign mem.dram_addr = (state_q == LATCH) ? mem.iram_data[ADDR_W-1:0] : inst_q[ADDR_W-1:0];
    assign mem.iram_addr = iaddr_q;
    assign mem.dram_we = we_q;
    assign mem.dram_wdata = wdata_q;
endmodule

// File: tb/tb_step_coordinator.sv
// tb_step_coordinator: vector table of small programs plus hand sequences for step mode, I2C hold, watchdog and reset.
module tb_step_coordinator;
    logic GCLK = 1'b0;
    logic RESET, EN, STEP_MODE, IICING, rst2, en2;
    logic ENC, CACK, TIMEOUT, CLKA, CLKB;
    logic w_enc, w_cack, w_tout, w_clka, w_clkb;
    logic [7:0] pc, DI, DO, w_di;
    logic [15:0] INST, w_inst, step_cnt, w_cnt;
    logic [15:0] iram [256];
    logic [7:0] dram [256];
    logic tb_we, pc_clr, mon_clr, clkb_pc;
    logic [7:0] tb_a, tb_d;
    int n_tests = 0, n_fail = 0;
    int enc_cyc, clka_n, clkb_n, we_cyc;
    logic ovl, clka_p, clkb_p;
    logic [7:0] di_p, di_at_a;
    typedef struct {
        string name;
        logic [15:0] i0, i1, i2;
        logic [7:0] d10, do_v, di;
        int steps, enc, we;
        logic [7:0] wd;
    } vec_t;
    vec_t vecs[5];
    vec_t exp_q[$];
    vec_t e;
    always #5 GCLK = ~GCLK;
    step_coordinator_if #(.ADDR_W(8), .INST_W(16), .DATA_W(8)) mif ();
    step_coordinator_if #(.ADDR_W(8), .INST_W(16), .DATA_W(8)) wif ();
    step_coordinator dut (
        .GCLK(GCLK), .RESET(RESET), .EN(EN), .STEP_MODE(STEP_MODE), .IICING(IICING),
        .ENC(ENC), .CACK(CACK), .TIMEOUT(TIMEOUT), .CLKA(CLKA), .CLKB(CLKB),
        .PC(pc), .INST(INST), .DI(DI), .DO(DO), .step_cnt(step_cnt), .mem(mif)
    );
    step_coordinator #(.MAX_STEPS(3)) dut2 (
        .GCLK(GCLK), .RESET(rst2), .EN(en2), .STEP_MODE(1'b0), .IICING(1'b0),
        .ENC(w_enc), .CACK(w_cack), .TIMEOUT(w_tout), .CLKA(w_clka), .CLKB(w_clkb),
        .PC(8'h00), .INST(w_inst), .DI(w_di), .DO(8'h00), .step_cnt(w_cnt), .mem(wif)
    );
    assign wif.iram_data = 16'h0000;
    assign wif.dram_rdata = 8'h00;
    always @(posedge GCLK) begin
        mif.iram_data <= iram[mif.iram_addr];
        if (tb_we) dram[tb_a] <= tb_d;
        else if (mif.dram_we) dram[mif.dram_addr] <= mif.dram_wdata;
        mif.dram_rdata <= dram[mif.dram_addr];
        clkb_pc <= CLKB;
        pc <= pc_clr ? 8'h00 : (CLKB && !clkb_pc) ? pc + 8'h01 : pc;
    end
    always @(negedge GCLK) begin
        if (mon_clr) begin
            enc_cyc <= 0; clka_n <= 0; clkb_n <= 0; we_cyc <= 0; ovl <= 1'b0; di_at_a <= 8'h00;
        end else begin
            enc_cyc <= enc_cyc + (ENC ? 1 : 0);
            we_cyc <= we_cyc + (mif.dram_we ? 1 : 0);
            if (CLKA && !clka_p) begin clka_n <= clka_n + 1; di_at_a <= di_p; end
            if (CLKB && !clkb_p) clkb_n <= clkb_n + 1;
            if ((CLKA && CLKB) || (mif.dram_we && (CLKA || CLKB))) ovl <= 1'b1;
        end
        clka_p <= CLKA;
        clkb_p <= CLKB;
        di_p <= DI;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask
    function automatic logic sig(input int w);
        case (w)
            0: return CACK;
            1: return CLKA;
            2: return CLKB;
            3: return !ENC;
            4: return mif.dram_we;
            default: return w_cack;
        endcase
    endfunction
    task automatic wait_for(input int w, input int budget, input string name);
        int k;
        k = 0;
        do begin @(negedge GCLK); k++; end while (!sig(w) && k < budget);
        n_tests++;
        if (!sig(w)) begin
            n_fail++;
            $display("FAIL wait_%s: not reached within %0d cycles, got 0 expected 1", name, budget);
        end
        #1;
    endtask
    task automatic do_reset();
        RESET = 1'b0; EN = 1'b0; IICING = 1'b0; STEP_MODE = 1'b0; pc_clr = 1'b1;
        repeat (2) @(negedge GCLK);
        RESET = 1'b1; pc_clr = 1'b0;
    endtask
    task automatic dram_wr(input logic [7:0] a, input logic [7:0] d);
        tb_a = a; tb_d = d; tb_we = 1'b1;
        @(negedge GCLK);
        tb_we = 1'b0;
    endtask
    task automatic mon_clear();
        mon_clr = 1'b1;
        @(negedge GCLK);
        #1 mon_clr = 1'b0;
    endtask
    task automatic load_prog(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        iram[0] = a; iram[1] = b; iram[2] = c;
    endtask
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        vecs[0] = '{"nop_nop_halt", 16'h0000, 16'h0000, 16'hF000, 8'h00, 8'h00, 8'h00, 2, 30, 0, 8'h00};
        vecs[1] = '{"ld_a5", 16'h1010, 16'hF000, 16'hF000, 8'hA5, 8'h00, 8'hA5, 1, 17, 0, 8'h00};
        vecs[2] = '{"st_3c", 16'h2020, 16'hF000, 16'hF000, 8'h00, 8'h3C, 8'h00, 1, 16, 1, 8'h3C};
        vecs[3] = '{"ld_st", 16'h1010, 16'h2020, 16'hF000, 8'h5A, 8'hC3, 8'h5A, 2, 31, 1, 8'hC3};
        vecs[4] = '{"halt_only", 16'hF000, 16'hF000, 16'hF000, 8'h77, 8'h00, 8'h00, 0, 2, 0, 8'h00};
        tb_we = 1'b0; tb_a = 8'h00; tb_d = 8'h00; mon_clr = 1'b1; DO = 8'h00;
        rst2 = 1'b0; en2 = 1'b0;
        do_reset();
        @(negedge GCLK); #1;
        chk("reset_ctl", 32'({ENC, CACK, TIMEOUT, CLKA, CLKB, mif.dram_we}), 32'h0);
        chk("reset_inst", 32'(INST), 32'h0);
        chk("reset_di", 32'(DI), 32'h0);
        chk("reset_step_cnt", 32'(step_cnt), 32'h0);
        chk("reset_iram_addr", 32'(mif.iram_addr), 32'h0);
        for (int i = 0; i < 5; i++) begin
            do_reset();
            load_prog(vecs[i].i0, vecs[i].i1, vecs[i].i2);
            dram_wr(8'h10, vecs[i].d10);
            dram_wr(8'h20, 8'h00);
            DO = vecs[i].do_v;
            mon_clear();
            exp_q.push_back(vecs[i]);
            EN = 1'b1;
            wait_for(0, 200, vecs[i].name);
            e = exp_q.pop_front();
            chk({e.name, "/steps"}, 32'(step_cnt), e.steps);
            chk({e.name, "/enc_cycles"}, enc_cyc, e.enc);
            chk({e.name, "/clka_pulses"}, clka_n, e.steps);
            chk({e.name, "/clkb_pulses"}, clkb_n, e.steps);
            chk({e.name, "/we_cycles"}, we_cyc, e.we);
            chk({e.name, "/overlap"}, 32'(ovl), 32'h0);
            chk({e.name, "/di"}, 32'(DI), 32'(e.di));
            chk({e.name, "/di_before_clka"}, 32'(di_at_a), 32'(e.di));
            chk({e.name, "/dram20"}, 32'(dram[8'h20]), 32'(e.wd));
            chk({e.name, "/inst_timeout_enc"}, 32'({INST, TIMEOUT, ENC}), 32'({16'hF000, 2'b00}));
            EN = 1'b0;
            repeat (2) @(negedge GCLK);
        end
        do_reset();
        load_prog(16'h0000, 16'h0000, 16'hF000);
        STEP_MODE = 1'b1;
        mon_clear();
        EN = 1'b1;
        wait_for(0, 100, "step1");
        chk("step1/cnt_enc_clkb", 32'({step_cnt, ENC, 8'(clkb_n)}), 32'({16'd1, 1'b0, 8'd1}));
        chk("step1/pc", 32'(pc), 32'h1);
        EN = 1'b0;
        repeat (2) @(negedge GCLK);
        chk("step1/cack_after_en_low", 32'(CACK), 32'h0);
        mon_clear();
        EN = 1'b1;
        wait_for(0, 100, "step2");
        chk("step2/cnt_clka_pc", 32'({step_cnt, 8'(clka_n), pc}), 32'({16'd1, 8'd1, 8'd2}));
        EN = 1'b0;
        repeat (2) @(negedge GCLK);
        EN = 1'b1;
        wait_for(0, 100, "step3_halt");
        chk("step3/cnt_clka", 32'({step_cnt, 8'(clka_n)}), 32'({16'd0, 8'd1}));
        do_reset();
        load_prog(16'h0000, 16'h0000, 16'hF000);
        mon_clear();
        EN = 1'b1;
        wait_for(1, 50, "iic_pha");
        IICING = 1'b1;
        wait_for(3, 50, "iic_hold");
        chk("hold/clkb_cnt_cack", 32'({8'(clkb_n), step_cnt, CACK}), 32'({8'd1, 16'd1, 1'b0}));
        repeat (3) @(negedge GCLK);
        chk("hold/enc_held_low", 32'({ENC, CLKA}), 32'h0);
        IICING = 1'b0;
        wait_for(0, 100, "hold_resume");
        chk("hold/resume_cnt_clka", 32'({step_cnt, 8'(clka_n)}), 32'({16'd2, 8'd2}));
        do_reset();
        load_prog(16'h0000, 16'h0000, 16'hF000);
        EN = 1'b1;
        wait_for(1, 50, "iic2_pha");
        IICING = 1'b1;
        wait_for(3, 50, "iic2_hold");
        EN = 1'b0;
        repeat (2) @(negedge GCLK);
        IICING = 1'b0;
        repeat (2) @(negedge GCLK);
        chk("hold_idle/enc_cack", 32'({ENC, CACK}), 32'h0);
        EN = 1'b1;
        wait_for(0, 100, "hold_idle_rerun");
        chk("hold_idle/cnt_restarted", 32'(step_cnt), 32'd1);
        EN = 1'b0;
        rst2 = 1'b1;
        @(negedge GCLK); #1;
        chk("wd/reset_tout_cnt", 32'({w_tout, w_cnt}), 32'h0);
        en2 = 1'b1;
        wait_for(5, 300, "wd_done");
        chk("wd/timeout_cnt_enc", 32'({w_tout, w_cnt, w_enc, w_clka}), 32'({1'b1, 16'd3, 2'b00}));
        en2 = 1'b0;
        repeat (2) @(negedge GCLK);
        chk("wd/timeout_cleared", 32'({w_tout, w_cack}), 32'h0);
        do_reset();
        load_prog(16'h0000, 16'h0000, 16'hF000);
        EN = 1'b1;
        wait_for(2, 50, "rst_phb");
        RESET = 1'b0;
        #1;
        chk("rst_phb/clocks_enc", 32'({CLKB, CLKA, ENC}), 32'h0);
        EN = 1'b0;
        repeat (2) @(negedge GCLK);
        RESET = 1'b1;
        repeat (2) @(negedge GCLK);
        chk("rst_phb/idle_after", 32'({ENC, CACK, step_cnt}), 32'h0);
        do_reset();
        load_prog(16'h2030, 16'hF000, 16'hF000);
        dram_wr(8'h30, 8'h11);
        DO = 8'hEE;
        EN = 1'b1;
        wait_for(4, 50, "rst_we");
        RESET = 1'b0;
        #1;
        chk("rst_we/we_dropped", 32'(mif.dram_we), 32'h0);
        EN = 1'b0;
        repeat (2) @(negedge GCLK);
        RESET = 1'b1;
        chk("rst_we/no_partial_write", 32'(dram[8'h30]), 32'h11);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
